// File: rtl/energy_accumulator.sv
// Ising-style energy accumulator: streams the rows of the coupling matrix J and
// accumulates +/-(h*scale + sum_j +/-J[r][j]) per row into a signed energy.
module energy_accumulator #(
  parameter int NUM_SPIN    = 256,
  parameter int BITJ        = 4,
  parameter int BITH        = 4,
  parameter int SCALING_BIT = 5,
  parameter int ENERGY_W    = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic                     clear_i,
  input  logic [NUM_SPIN-1:0]      spin_i,
  input  logic [NUM_SPIN*BITH-1:0] hbias_i,
  input  logic [SCALING_BIT-1:0]   hscaling_i,
  input  logic                     h_neg_i,
  input  logic                     little_endian_i,
  input  logic                     w_valid_i,
  output logic                     w_ready_o,
  input  logic [NUM_SPIN*BITJ-1:0] w_row_i,
  output logic                     busy_o,
  output logic                     energy_valid_o,
  input  logic                     energy_ready_i,
  output logic [ENERGY_W-1:0]      energy_o
);

  localparam int CNT_W = (NUM_SPIN > 1) ? $clog2(NUM_SPIN) : 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(NUM_SPIN - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_row_cnt;
  logic [ENERGY_W-1:0]     r_acc;
  logic [ENERGY_W-1:0]     r_energy;
  logic [NUM_SPIN-1:0]     r_spin;
  logic [NUM_SPIN*BITH-1:0] r_hbias;
  logic [SCALING_BIT-1:0]  r_hscaling;
  logic                    r_h_neg;
  logic                    r_little_endian;
  logic                    r_w_ready;
  logic                    r_busy;
  logic                    r_energy_valid;

  logic [CNT_W-1:0]        w_row_idx;
  logic                    w_row_sign;
  logic [BITH-1:0]         w_h;
  logic [ENERGY_W-1:0]     w_h_ext;
  logic [ENERGY_W-1:0]     w_scale_ext;
  logic [ENERGY_W-1:0]     w_row_sum;
  logic [ENERGY_W-1:0]     w_term;
  logic [ENERGY_W-1:0]     w_acc_next;
  logic [ENERGY_W-1:0]     w_energy_next;
  logic                    w_row_fire;
  logic                    w_accept;

  function automatic logic [ENERGY_W-1:0] sext_w(input logic [BITJ-1:0] v);
    return {{(ENERGY_W-BITJ){v[BITJ-1]}}, v};
  endfunction

  // Endian mode only remaps the outer (row) index; the inner j index is always direct.
  assign w_row_idx   = r_little_endian ? r_row_cnt : LAST_ROW - r_row_cnt;
  assign w_row_sign  = r_spin[w_row_idx];
  assign w_h         = r_hbias[w_row_idx*BITH +: BITH];
  assign w_h_ext     = {{(ENERGY_W-BITH){w_h[BITH-1]}}, w_h};
  assign w_scale_ext = {{(ENERGY_W-SCALING_BIT){1'b0}}, r_hscaling};

  // NOTE: the running sum gets its default before the loop so every path assigns it and no latch is inferred.
  always_comb begin
    w_row_sum = '0;
    for (int j = 0; j < NUM_SPIN; j++) begin
      if (r_spin[j]) w_row_sum = w_row_sum + sext_w(w_row_i[j*BITJ +: BITJ]);
      else           w_row_sum = w_row_sum - sext_w(w_row_i[j*BITJ +: BITJ]);
    end
  end

  // Unsigned ENERGY_W arithmetic gives the same low bits as two's complement, so wraps are free.
  assign w_term        = w_h_ext * w_scale_ext + w_row_sum;
  assign w_acc_next    = w_row_sign ? r_acc + w_term : r_acc - w_term;
  assign w_energy_next = r_h_neg ? -w_acc_next : w_acc_next;

  assign w_row_fire = w_valid_i & r_w_ready;
  assign w_accept   = start_i & ((r_state == IDLE) ||
                                 ((r_state == DONE) && energy_ready_i));

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state         <= IDLE;
      r_row_cnt       <= '0;
      r_acc           <= '0;
      r_energy        <= '0;
      r_spin          <= '0;
      r_hbias         <= '0;
      r_hscaling      <= '0;
      r_h_neg         <= 1'b0;
      r_little_endian <= 1'b0;
      r_w_ready       <= 1'b0;
      r_busy          <= 1'b0;
      r_energy_valid  <= 1'b0;
    end else if (clear_i) begin
      r_state        <= IDLE;
      r_row_cnt      <= '0;
      r_acc          <= '0;
      r_w_ready      <= 1'b0;
      r_busy         <= 1'b0;
      r_energy_valid <= 1'b0;
    end else if (w_accept) begin
      r_spin          <= spin_i;
      r_hbias         <= hbias_i;
      r_hscaling      <= hscaling_i;
      r_h_neg         <= h_neg_i;
      r_little_endian <= little_endian_i;
      r_row_cnt       <= '0;
      r_acc           <= '0;
      r_state         <= ACCUM;
      r_w_ready       <= 1'b1;
      r_busy          <= 1'b1;
      r_energy_valid  <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_row_fire) begin
            r_acc <= w_acc_next;
            if (r_row_cnt == LAST_ROW) begin
              r_energy       <= w_energy_next;
              r_state        <= DONE;
              r_w_ready      <= 1'b0;
              r_energy_valid <= 1'b1;
            end else begin
              r_row_cnt <= r_row_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (energy_ready_i) begin
            r_state        <= IDLE;
            r_busy         <= 1'b0;
            r_energy_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign w_ready_o      = r_w_ready;
  assign busy_o         = r_busy;
  assign energy_valid_o = r_energy_valid;
  assign energy_o       = r_energy;

endmodule

// File: tb/tb_energy_accumulator.sv
// Directed bench for energy_accumulator (NUM_SPIN=4, BITJ=4, BITH=4, SCALING_BIT=4, ENERGY_W=32).
module tb_energy_accumulator;

  localparam int NS = 4;
  localparam int BJ = 4;
  localparam int BH = 4;
  localparam int SB = 4;
  localparam int EW = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              clear;
  logic [NS-1:0]     spin;
  logic [NS*BH-1:0]  hbias;
  logic [SB-1:0]     hscaling;
  logic              h_neg;
  logic              le;
  logic              w_valid;
  logic              w_ready;
  logic [NS*BJ-1:0]  w_row;
  logic              busy;
  logic              e_valid;
  logic              e_ready;
  logic [EW-1:0]     energy;

  int n_checks = 0;
  int n_errors = 0;

  energy_accumulator #(
    .NUM_SPIN(NS), .BITJ(BJ), .BITH(BH), .SCALING_BIT(SB), .ENERGY_W(EW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .clear_i(clear),
    .spin_i(spin), .hbias_i(hbias), .hscaling_i(hscaling), .h_neg_i(h_neg),
    .little_endian_i(le), .w_valid_i(w_valid), .w_ready_o(w_ready),
    .w_row_i(w_row), .busy_o(busy), .energy_valid_o(e_valid),
    .energy_ready_i(e_ready), .energy_o(energy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NS-1:0]      spin;
    logic [4*NS*BJ-1:0] rows;   // row r at bits [r*16 +: 16]
    logic [NS*BH-1:0]   hbias;
    logic [SB-1:0]      hs;
    logic               h_neg;
    logic               le;
    logic signed [EW-1:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)",
               name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_inputs(input vec_t v);
    spin     = v.spin;
    hbias    = v.hbias;
    hscaling = v.hs;
    h_neg    = v.h_neg;
    le       = v.le;
  endtask

  // Start a job from IDLE; a garbage row offered in IDLE must be ignored.
  task automatic start_job(input vec_t v);
    apply_inputs(v);
    w_valid = 1'b1;
    w_row   = 16'h7777;
    start   = 1'b1;
    step();
    start   = 1'b0;
    w_valid = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("w_ready_after_start", {31'd0, w_ready}, 32'd1);
  endtask

  // Feed rows 0..3; optional random gaps; optional start poke with different inputs mid-ACCUM.
  task automatic feed(input vec_t v, input bit gaps, input bit poke_start);
    for (int r = 0; r < NS; r++) begin
      int g;
      g = gaps ? int'($urandom_range(1, 3)) : 0;
      for (int k = 0; k < g; k++) begin
        w_valid = 1'b0;
        w_row   = 16'hFFFF;
        if (poke_start && r == 2 && k == 0) begin
          start = 1'b1;
          spin  = ~v.spin;
          h_neg = ~v.h_neg;
        end
        step();
        start = 1'b0;
        spin  = v.spin;
        h_neg = v.h_neg;
        check("w_ready_during_gap", {31'd0, w_ready}, 32'd1);
      end
      w_valid = 1'b1;
      w_row   = v.rows[r*16 +: 16];
      step();
      w_valid = 1'b0;
      w_row   = 16'hFFFF;
      if (r < NS - 1) check("valid_low_before_last_row", {31'd0, e_valid}, 32'd0);
    end
    check("valid_one_cycle_after_last_row", {31'd0, e_valid}, 32'd1);
    check("energy_value", energy, v.exp);
    check("w_ready_low_in_done", {31'd0, w_ready}, 32'd0);
    check("busy_in_done", {31'd0, busy}, 32'd1);
  endtask

  // Hold the result for 'hold' cycles, then handshake it and return to IDLE.
  task automatic release_result(input logic [EW-1:0] exp, input int hold);
    for (int k = 0; k < hold; k++) begin
      step();
      check("valid_held", {31'd0, e_valid}, 32'd1);
      check("energy_held", energy, exp);
    end
    e_ready = 1'b1;
    step();
    e_ready = 1'b0;
    check("valid_drop_after_handshake", {31'd0, e_valid}, 32'd0);
    check("busy_drop_after_handshake", {31'd0, busy}, 32'd0);
    check("energy_kept_in_idle", energy, exp);
  endtask

  initial begin
    vecs[0] = '{4'b1111, 64'h1111_1111_1111_1111, 16'h0000, 4'd0, 1'b0, 1'b1, 32'sd16};
    vecs[1] = '{4'b1111, 64'h1111_1111_1111_1111, 16'h0000, 4'd0, 1'b1, 1'b1, -32'sd16};
    vecs[2] = '{4'b0000, 64'h1111_1111_1111_1111, 16'h2222, 4'd3, 1'b0, 1'b1, -32'sd8};
    vecs[3] = '{4'b0001, 64'h0000_0000_0000_1111, 16'h0000, 4'd0, 1'b0, 1'b1, -32'sd2};
    vecs[4] = '{4'b0001, 64'h0000_0000_0000_1111, 16'h0000, 4'd0, 1'b0, 1'b0, 32'sd2};
    vecs[5] = '{4'b1010, 64'h0000_0000_0000_8701, 16'h7D2F, 4'd5, 1'b0, 1'b1, 32'sd81};
    vecs[6] = '{4'b1010, 64'h0000_0000_0000_8701, 16'h7D2F, 4'd5, 1'b1, 1'b0, -32'sd49};

    rst_n = 1'b0; start = 1'b0; clear = 1'b0; spin = '0; hbias = '0;
    hscaling = '0; h_neg = 1'b0; le = 1'b0; w_valid = 1'b0; w_row = '0; e_ready = 1'b0;
    #12;
    check("reset_energy", energy, 32'd0);
    check("reset_valid", {31'd0, e_valid}, 32'd0);
    check("reset_w_ready", {31'd0, w_ready}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++) begin
      start_job(vecs[i]);
      feed(vecs[i], 1'b0, 1'b0);
      release_result(vecs[i].exp, 0);
    end

    // Gapped rows plus an ignored start mid-ACCUM, then a 5-cycle result stall.
    start_job(vecs[5]);
    feed(vecs[5], 1'b1, 1'b1);
    release_result(vecs[5].exp, 5);

    // Start accepted in DONE together with the result handshake.
    start_job(vecs[0]);
    feed(vecs[0], 1'b0, 1'b0);
    apply_inputs(vecs[2]);
    start   = 1'b1;
    e_ready = 1'b1;
    step();
    start   = 1'b0;
    e_ready = 1'b0;
    check("b2b_valid_drop", {31'd0, e_valid}, 32'd0);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check("b2b_w_ready", {31'd0, w_ready}, 32'd1);
    check("b2b_energy_kept", energy, 32'd16);
    feed(vecs[2], 1'b0, 1'b0);
    release_result(vecs[2].exp, 1);

    // Asynchronous reset after two rows discards the partial sum.
    start_job(vecs[0]);
    for (int r = 0; r < 2; r++) begin
      w_valid = 1'b1;
      w_row   = vecs[0].rows[r*16 +: 16];
      step();
      w_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_energy", energy, 32'd0);
    check("midrst_valid", {31'd0, e_valid}, 32'd0);
    check("midrst_w_ready", {31'd0, w_ready}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    start_job(vecs[0]);
    feed(vecs[0], 1'b0, 1'b0);
    release_result(vecs[0].exp, 0);

    // clear wins over start and result handshake in DONE.
    start_job(vecs[0]);
    feed(vecs[0], 1'b0, 1'b0);
    apply_inputs(vecs[2]);
    clear   = 1'b1;
    start   = 1'b1;
    e_ready = 1'b1;
    step();
    clear   = 1'b0;
    start   = 1'b0;
    e_ready = 1'b0;
    check("clear_busy", {31'd0, busy}, 32'd0);
    check("clear_valid", {31'd0, e_valid}, 32'd0);
    check("clear_w_ready", {31'd0, w_ready}, 32'd0);
    check("clear_energy_kept", energy, 32'd16);
    step();
    check("clear_stays_idle", {31'd0, w_ready}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/energy_accumulator.md
ENERGY_ACCUMULATOR -- requirements
Module: energy_accumulator

Interface
REQ-001: Parameters SHALL be, one per line (name, default, meaning):
- NUM_SPIN, 256, spins per vector and rows of J
- BITJ, 4, signed coupling width
- BITH, 4, signed bias width
- SCALING_BIT, 5, unsigned bias-scaling width
- ENERGY_W, 32, signed energy accumulator width
REQ-002: Ports SHALL be, one per line (name, direction, width, meaning):
- clk_i, in, 1, sole clock
- rst_ni, in, 1, asynchronous active-low reset
- start_i, in, 1, start request; captures the spin/bias/mode inputs below
- clear_i, in, 1, synchronous abort
- spin_i, in, NUM_SPIN, spin vector (1 = +1, 0 = -1)
- hbias_i, in, NUM_SPIN*BITH, packed signed biases (slice k at k*BITH)
- hscaling_i, in, SCALING_BIT, unsigned bias scale
- h_neg_i, in, 1, negate final energy
- little_endian_i, in, 1, spin/bias indexing mode
- w_valid_i, in, 1, weight row valid
- w_ready_o, out, 1, weight row ready
- w_row_i, in, NUM_SPIN*BITJ, row r of J (slice j at j*BITJ)
- busy_o, out, 1, computation in progress
- energy_valid_o, out, 1, result valid
- energy_ready_i, in, 1, result accepted
- energy_o, out, ENERGY_W, signed energy

Function
REQ-003: FSM SHALL have states IDLE, ACCUM and DONE.
REQ-004: start_i SHALL be accepted only in IDLE, or in DONE in the same cycle as the result handshake; on acceptance, spin_i, hbias_i, hscaling_i, h_neg_i and little_endian_i SHALL be registered, the row counter and accumulator cleared, and the FSM SHALL enter ACCUM.
REQ-005: start_i SHALL be ignored while in ACCUM.
REQ-006: w_ready_o SHALL be 1 exactly in ACCUM; a row is consumed on w_valid_i & w_ready_o, with rows arriving in order r = 0..NUM_SPIN-1.
REQ-007: For consumed row r, the block SHALL use c = spin[r] and h = hbias slice r if little-endian, else c = spin[NUM_SPIN-1-r] and h = hbias slice NUM_SPIN-1-r.
REQ-008: Row term SHALL be t = h*hscaling + sum over j of (spin[j] ? w_rj : -w_rj); the inner index j SHALL always be direct, with no endian mapping.
REQ-009: The accumulator SHALL add t if c = 1 and subtract t if c = 0, one row per handshake, with no throughput bubble between rows.
REQ-010: Arithmetic width rules:
- w and h SHALL be sign-extended, hscaling zero-extended.
- All sums SHALL be ENERGY_W two's complement, wrapping modulo 2^ENERGY_W, with no saturation.
REQ-011: On the handshake of row NUM_SPIN-1, the block SHALL register energy_o = h_neg ? -acc_final : acc_final and enter DONE; energy_valid_o SHALL rise the next cycle, giving a latency of 1 cycle after the last row.
REQ-012: In DONE, energy_valid_o = 1 and energy_o SHALL hold stable until energy_ready_i; then the FSM SHALL go to IDLE (or to ACCUM per REQ-004) and energy_valid_o SHALL drop.
REQ-013: energy_o SHALL retain the last result in IDLE; it SHALL change only at REQ-011 or on reset.
REQ-014: busy_o SHALL be 1 in ACCUM and DONE, 0 in IDLE.
REQ-015: clear_i SHALL force IDLE the next cycle from any state, clearing the counter and accumulator; energy_o SHALL be kept.
REQ-016: clear_i SHALL take priority over start_i and over any simultaneous row or result handshake.
REQ-017: w_valid_i SHALL be ignored outside ACCUM; gaps in w_valid_i SHALL only stall the computation.

Reset
REQ-018: While rst_ni = 0, asynchronously, the FSM SHALL be IDLE, the counter and accumulator 0, all captured inputs 0, and energy_o = 0, energy_valid_o = 0, w_ready_o = 0, busy_o = 0.
REQ-019: After rst_ni rises, the first start_i SHALL be accepted; reset mid-ACCUM SHALL discard partial sums.

Verification (test config NUM_SPIN=4, BITJ=4, BITH=4, SCALING_BIT=4, ENERGY_W=32)
REQ-020: Bench: spin=4'b1111, all w=+1, h=0, h_neg=0, 4 back-to-back rows -> energy_o=16, valid 1 cycle after row 3; with h_neg=1 -> -16.
REQ-021: Bench: spin=4'b0000, all w=+1, all h=2, hscaling=3 -> each row t=2 subtracted -> energy_o=-8.
REQ-022: Bench: spin=4'b0001, row0 all +1, other rows and h zero -> little_endian=1 gives -2; little_endian=0 gives +2.
REQ-023: Bench: random w_valid_i gaps, then energy_ready_i held low 5 cycles -> result identical to the no-gap run; energy_o and energy_valid_o stable until the handshake.
REQ-024: Bench: rst_ni pulsed low after 2 rows -> all outputs 0 immediately; a new start with REQ-020 stimulus -> 16.
REQ-025: Bench: clear_i asserted together with start_i in DONE after a result of 16 -> IDLE next cycle, energy_o stays 16, busy_o = 0.
